// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  // Clear sequencer states: CLEAR sweeps zeros through the array, IDLE serves traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int DATA_BITS_DEF = 16;
  localparam int REG_COUNT_DEF = 16;

  // Base bit offset of lane 'port' inside a packed multi-port bus of lane width 'width'.
  function automatic int rd_slice(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write ports, packed read ports, clear request/busy.
// Handshake: there is no backpressure. A write enable is accepted at the rising
// edge whenever Busy is low and dropped whenever Busy is high; Clear_Req is a
// one-cycle request honoured only while the sequencer is idle.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int ADDR_W    = 4,
  parameter int NUM_RD    = 2
) ();

  logic                        Clear_Req;
  logic                        Busy;
  state_t                      State_Dbg;
  logic                        W0_En;
  logic [ADDR_W-1:0]           W0_Addr;
  logic [DATA_BITS-1:0]        W0_Data;
  logic                        W1_En;
  logic [ADDR_W-1:0]           W1_Addr;
  logic [DATA_BITS-1:0]        W1_Data;
  logic [NUM_RD*ADDR_W-1:0]    Rd_Addr;
  logic [NUM_RD*DATA_BITS-1:0] Rd_Data;

  // Control unit / bench side.
  modport master (
    output Clear_Req, W0_En, W0_Addr, W0_Data, W1_En, W1_Addr, W1_Data, Rd_Addr,
    input  Busy, State_Dbg, Rd_Data
  );

  // Register file side.
  modport slave (
    input  Clear_Req, W0_En, W0_Addr, W0_Data, W1_En, W1_Addr, W1_Data, Rd_Addr,
    output Busy, State_Dbg, Rd_Data
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks a pointer over every register after reset or on
// Clear_Req, emitting a zero-write strobe per cycle and holding Busy high.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int REG_COUNT = REG_COUNT_DEF,
  parameter int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Clear_Req,
  output state_t            State,
  output logic              Busy,
  output logic              Clr_We,
  output logic [ADDR_W-1:0] Clr_Addr
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(REG_COUNT - 1);

  // Sequencer state, pointer and Busy all update together at the edge.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      State    <= CLEAR;
      Busy     <= 1'b1;
      Clr_Addr <= '0;
    end else begin
      case (State)
        CLEAR: begin
          if (Clr_Addr == LAST_PTR) begin
            State    <= IDLE;
            Busy     <= 1'b0;
            Clr_Addr <= '0;
          end else begin
            Clr_Addr <= Clr_Addr + 1'b1;
          end
        end
        IDLE: begin
          if (Clear_Req) begin
            State    <= CLEAR;
            Busy     <= 1'b1;
            Clr_Addr <= '0;
          end
        end
        default: begin
          State    <= CLEAR;
          Busy     <= 1'b1;
          Clr_Addr <= '0;
        end
      endcase
    end
  end

  // The sweep writes only once reset is released; held reset leaves the array alone.
  assign Clr_We = Busy & Rst_n;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports
// (W1 wins on an address clash), hardware clear sweep, optional zero register.
// Optional macro REGFILE_BYPASS_EN: same-cycle write data is forwarded to
// matching read ports while idle (W1 before W0).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int REG_COUNT = REG_COUNT_DEF,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 0,
  parameter int ADDR_W    = $clog2(REG_COUNT)
) (
  input logic         Clk,
  input logic         Rst_n,
  regfile_mp_if.slave bus
);

  logic [DATA_BITS-1:0]        mem [REG_COUNT];
  state_t                      state;
  logic                        busy;
  logic                        clr_we;
  logic [ADDR_W-1:0]           clr_addr;
  logic                        w0_ok;
  logic                        w1_ok;
  logic [NUM_RD*DATA_BITS-1:0] rd_data;
  logic [ADDR_W-1:0]           ra;
  logic [DATA_BITS-1:0]        rv;

  // An address is live if it exists and is not the hard-wired zero register.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return (32'(a) < REG_COUNT) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  regfile_clear_fsm #(
    .REG_COUNT(REG_COUNT),
    .ADDR_W   (ADDR_W)
  ) u_clear_fsm (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Clear_Req(bus.Clear_Req),
    .State    (state),
    .Busy     (busy),
    .Clr_We   (clr_we),
    .Clr_Addr (clr_addr)
  );

  // Qualify each write port: idle, out of reset, enabled, live address.
  always_comb begin
    w0_ok = bus.W0_En && !busy && Rst_n && addr_live(bus.W0_Addr);
    w1_ok = bus.W1_En && !busy && Rst_n && addr_live(bus.W1_Addr);
  end

  // Array update: clear sweep owns the array while busy; otherwise W1 is
  // written last so it overrides W0 on the same address.
  always_ff @(posedge Clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (w0_ok) mem[bus.W0_Addr] <= bus.W0_Data;
      if (w1_ok) mem[bus.W1_Addr] <= bus.W1_Data;
    end
  end

  // Read muxes: zero while busy or for dead addresses, else stored (or bypassed) data.
  always_comb begin
    rd_data = '0;
    ra      = '0;
    rv      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = bus.Rd_Addr[rd_slice(i, ADDR_W) +: ADDR_W];
      rv = '0;
      if (!busy && addr_live(ra)) begin
        rv = mem[ra];
`ifdef REGFILE_BYPASS_EN
        if (w1_ok && (bus.W1_Addr == ra)) begin
          rv = bus.W1_Data;
        end else if (w0_ok && (bus.W0_Addr == ra)) begin
          rv = bus.W0_Data;
        end
`else
        // Without forwarding, a write becomes visible the cycle after its edge.
`endif
      end
      rd_data[rd_slice(i, DATA_BITS) +: DATA_BITS] = rv;
    end
  end

  assign bus.Rd_Data   = rd_data;
  assign bus.Busy      = busy;
  assign bus.State_Dbg = state;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (NUM_RD=2) and a ZERO_REG=1,
// NUM_RD=3 instance sharing clock and reset.
module tb_regfile_mp;
  import regfile_pkg::*;

  // ---------------- clock / reset ----------------
  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  regfile_mp_if #(.DATA_BITS(16), .ADDR_W(4), .NUM_RD(2)) if_a ();
  regfile_mp_if #(.DATA_BITS(16), .ADDR_W(4), .NUM_RD(3)) if_z ();

  regfile_mp #(.DATA_BITS(16), .REG_COUNT(16), .NUM_RD(2), .ZERO_REG(0)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .bus(if_a)
  );
  regfile_mp #(.DATA_BITS(16), .REG_COUNT(16), .NUM_RD(3), .ZERO_REG(1)) dut_z (
    .Clk(Clk), .Rst_n(Rst_n), .bus(if_z)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    logic [31:0] e;
    exp_q.push_back(exp_v);
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_a(input logic [31:0] w0en, w0a, w0d, w1en, w1a, w1d);
    if_a.W0_En   = w0en[0];
    if_a.W0_Addr = w0a[3:0];
    if_a.W0_Data = w0d[15:0];
    if_a.W1_En   = w1en[0];
    if_a.W1_Addr = w1a[3:0];
    if_a.W1_Data = w1d[15:0];
  endtask

  task automatic rd_a(input logic [31:0] a0, a1);
    if_a.Rd_Addr = {a1[3:0], a0[3:0]};
  endtask

  task automatic drive_z(input logic [31:0] w0en, w0a, w0d, w1en, w1a, w1d);
    if_z.W0_En   = w0en[0];
    if_z.W0_Addr = w0a[3:0];
    if_z.W0_Data = w0d[15:0];
    if_z.W1_En   = w1en[0];
    if_z.W1_Addr = w1a[3:0];
    if_z.W1_Data = w1d[15:0];
  endtask

  task automatic rd_z(input logic [31:0] a0, a1, a2);
    if_z.Rd_Addr = {a2[3:0], a1[3:0], a0[3:0]};
  endtask

  // Counts cycles with Busy high, starting now, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (if_a.Busy === 1'b1 && n < 100) begin
      n++;
      tick;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] w0_en, w0_addr, w0_data;
    logic [31:0] w1_en, w1_addr, w1_data;
    logic [31:0] ra0, ra1;
    logic [31:0] exp0, exp1;    // same-cycle read without forwarding
    logic [31:0] bexp0, bexp1;  // same-cycle read with forwarding
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] e0, e1;

    //            w0en w0a  w0d      w1en w1a  w1d      ra0 ra1 exp0     exp1     bexp0    bexp1
    vecs[0]  = '{1, 5, 'h1234, 0, 0,  0,       5,  6,  0,       0,       'h1234,  0};
    vecs[1]  = '{0, 0, 0,       0, 0,  0,       5,  6,  'h1234,  0,       'h1234,  0};
    vecs[2]  = '{1, 3, 'hAAAA,  1, 3,  'h5555,  3,  5,  0,       'h1234,  'h5555,  'h1234};
    vecs[3]  = '{0, 0, 0,       0, 0,  0,       3,  3,  'h5555,  'h5555,  'h5555,  'h5555};
    vecs[4]  = '{1, 2, 'h1111,  1, 4,  'h2222,  2,  4,  0,       0,       'h1111,  'h2222};
    vecs[5]  = '{0, 0, 0,       0, 0,  0,       2,  4,  'h1111,  'h2222,  'h1111,  'h2222};
    vecs[6]  = '{0, 0, 0,       1, 15, 'hBEEF,  15, 0,  0,       0,       'hBEEF,  0};
    vecs[7]  = '{1, 5, 'hFFFF,  1, 6,  'h0001,  6,  5,  0,       'h1234,  'h0001,  'hFFFF};
    vecs[8]  = '{0, 0, 0,       0, 0,  0,       5,  6,  'hFFFF,  'h0001,  'hFFFF,  'h0001};
    vecs[9]  = '{0, 7, 'hDEAD,  0, 7,  'hDEAD,  15, 7,  'hBEEF,  0,       'hBEEF,  0};
    vecs[10] = '{0, 0, 0,       0, 0,  0,       7,  15, 0,       'hBEEF,  0,       'hBEEF};

    if_a.Clear_Req = 1'b0;
    if_z.Clear_Req = 1'b0;
    drive_a(0, 0, 0, 0, 0, 0);
    rd_a(0, 0);
    drive_z(0, 0, 0, 0, 0, 0);
    rd_z(0, 0, 0);

    // ---- 1: reset, sweep length, all zero ----
    Rst_n = 1'b0;
    repeat (3) tick;
    cmp("busy_in_reset", 32'(if_a.Busy), 1);
    cmp("state_in_reset", 32'(if_a.State_Dbg), 32'(CLEAR));
    Rst_n = 1'b1;
    count_busy(n);
    cmp("busy_cycles_after_reset", 32'(n), 16);
    cmp("state_idle_after_reset", 32'(if_a.State_Dbg), 32'(IDLE));
    for (int i = 0; i < 16; i++) begin
      rd_a(i, 15 - i);
      #1;
      cmp($sformatf("reset_zero_p0_r%0d", i), 32'(if_a.Rd_Data[15:0]), 0);
      cmp($sformatf("reset_zero_p1_r%0d", 15 - i), 32'(if_a.Rd_Data[31:16]), 0);
      tick;
    end

    // ---- 2/3: table-driven writes, priority, same-cycle visibility ----
    for (int k = 0; k < 11; k++) begin
      drive_a(vecs[k].w0_en, vecs[k].w0_addr, vecs[k].w0_data,
              vecs[k].w1_en, vecs[k].w1_addr, vecs[k].w1_data);
      rd_a(vecs[k].ra0, vecs[k].ra1);
      #1;
`ifdef REGFILE_BYPASS_EN
      e0 = vecs[k].bexp0;
      e1 = vecs[k].bexp1;
`else
      e0 = vecs[k].exp0;
      e1 = vecs[k].exp1;
`endif
      cmp($sformatf("vec%0d_rd0", k), 32'(if_a.Rd_Data[15:0]), e0);
      cmp($sformatf("vec%0d_rd1", k), 32'(if_a.Rd_Data[31:16]), e1);
      tick;
    end
    drive_a(0, 0, 0, 0, 0, 0);

    // ---- 4: fill, Clear_Req sweep, writes ignored while busy ----
    for (int i = 0; i < 16; i += 2) begin
      drive_a(1, i, i + 'h100, 1, i + 1, i + 1 + 'h100);
      tick;
    end
    drive_a(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      rd_a(i, 15 - i);
      #1;
      cmp($sformatf("fill_p0_r%0d", i), 32'(if_a.Rd_Data[15:0]), 32'(i + 'h100));
      cmp($sformatf("fill_p1_r%0d", 15 - i), 32'(if_a.Rd_Data[31:16]), 32'(15 - i + 'h100));
      tick;
    end
    drive_a(1, 9, 'h7777, 0, 0, 0);
    if_a.Clear_Req = 1'b1;
    #1;
    cmp("busy_before_clear_req", 32'(if_a.Busy), 0);
    tick;
    drive_a(1, 1, 'hDEAD, 1, 3, 'hBEEF);
    rd_a(1, 3);
    n = 0;
    while (if_a.Busy === 1'b1 && n < 100) begin
      if_a.Clear_Req = (n == 5);
      #1;
      cmp($sformatf("busy_rd0_zero_c%0d", n), 32'(if_a.Rd_Data[15:0]), 0);
      cmp($sformatf("busy_rd1_zero_c%0d", n), 32'(if_a.Rd_Data[31:16]), 0);
      n++;
      tick;
    end
    if_a.Clear_Req = 1'b0;
    cmp("busy_cycles_clear_req", 32'(n), 16);
    drive_a(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      rd_a(i, 15 - i);
      #1;
      cmp($sformatf("cleared_p0_r%0d", i), 32'(if_a.Rd_Data[15:0]), 0);
      cmp($sformatf("cleared_p1_r%0d", 15 - i), 32'(if_a.Rd_Data[31:16]), 0);
      tick;
    end

    // ---- 5: reset mid-sweep restarts from zero ----
    drive_a(1, 12, 'h4321, 1, 0, 'h0042);
    tick;
    drive_a(0, 0, 0, 0, 0, 0);
    rd_a(12, 0);
    #1;
    cmp("pre_sweep_r12", 32'(if_a.Rd_Data[15:0]), 'h4321);
    cmp("pre_sweep_r0", 32'(if_a.Rd_Data[31:16]), 'h0042);
    if_a.Clear_Req = 1'b1;
    tick;
    if_a.Clear_Req = 1'b0;
    repeat (7) tick;
    cmp("busy_mid_sweep", 32'(if_a.Busy), 1);
    Rst_n = 1'b0;
    tick;
    cmp("busy_in_mid_reset", 32'(if_a.Busy), 1);
    Rst_n = 1'b1;
    count_busy(n);
    cmp("busy_cycles_after_mid_reset", 32'(n), 16);
    rd_a(12, 0);
    #1;
    cmp("post_sweep_r12", 32'(if_a.Rd_Data[15:0]), 0);
    cmp("post_sweep_r0", 32'(if_a.Rd_Data[31:16]), 0);
    tick;

    // ---- 6: zero register, three read ports ----
    cmp("z_idle", 32'(if_z.Busy), 0);
    drive_z(1, 0, 'hFFFF, 0, 0, 0);
    rd_z(0, 0, 0);
    #1;
    cmp("z_same_cycle_p0", 32'(if_z.Rd_Data[15:0]), 0);
    cmp("z_same_cycle_p2", 32'(if_z.Rd_Data[47:32]), 0);
    tick;
    drive_z(1, 0, 'h1234, 1, 0, 'h5678);
    #1;
    cmp("z_r0_p0", 32'(if_z.Rd_Data[15:0]), 0);
    cmp("z_r0_p1", 32'(if_z.Rd_Data[31:16]), 0);
    cmp("z_r0_p2", 32'(if_z.Rd_Data[47:32]), 0);
    tick;
    drive_z(0, 0, 0, 1, 15, 'hBEEF);
    rd_z(0, 0, 15);
    #1;
`ifdef REGFILE_BYPASS_EN
    cmp("z_r15_same_cycle", 32'(if_z.Rd_Data[47:32]), 'hBEEF);
`else
    cmp("z_r15_same_cycle", 32'(if_z.Rd_Data[47:32]), 0);
`endif
    cmp("z_r0_after_conflict", 32'(if_z.Rd_Data[15:0]), 0);
    tick;
    drive_z(1, 1, 'h0A0A, 1, 0, 'h5555);
    rd_z(0, 15, 15);
    #1;
    cmp("z_r15_p1", 32'(if_z.Rd_Data[31:16]), 'hBEEF);
    cmp("z_r15_p2", 32'(if_z.Rd_Data[47:32]), 'hBEEF);
    tick;
    drive_z(0, 0, 0, 0, 0, 0);
    rd_z(1, 0, 15);
    #1;
    cmp("z_r1_p0", 32'(if_z.Rd_Data[15:0]), 'h0A0A);
    cmp("z_r0_w1_dropped", 32'(if_z.Rd_Data[31:16]), 0);
    cmp("z_r15_p2_hold", 32'(if_z.Rd_Data[47:32]), 'hBEEF);
    tick;

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
